gps2utc_ff: RTL and testbench
=============================

// Module: gps2utc_ff
// PURPOSE
//  Converts GPS time (10-bit week number + time-of-week in seconds) into a UTC calendar stamp:
//  year (yy), day-of-year, hh:mm:ss.
//  Runs once per PPS, sits between the GNSS Z-count/TOW decoder and the HaveQuick time-of-day
//  formatter.
//  Multi-cycle iterative datapath: no dividers or multipliers wider than constant shifts/adds.
// PARAMETERS
//  LEAP_SEC     18  GPS-UTC leap-second offset subtracted from GPS time
//  WN_ROLLOVER  2   number of 1024-week rollovers added to wn10 (full week = wn10 + 1024*WN_ROLLOVER)
// PORTS
//  clk      in   1   system clock; one clock domain
//  rst      in   1   reset; synchronous and active-low
//  start    in   1   PPS strobe; conversion triggers on its rising edge, level may last several cycles
//  wn10     in   10  GPS week number modulo 1024
//  tow_sec  in   20  GPS seconds of week, nominal 0..604799
//  valid    out  1   one-cycle pulse: hh/mm/ss/doy/yy hold a new result
//  hh       out  6   UTC hour 0..23
//  mm       out  6   UTC minute 0..59
//  ss       out  6   UTC second 0..59
//  doy      out  9   UTC day of year 1..366
//  yy       out  7   UTC year - 2000, 0..99
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state IDLE, valid=0; hh, mm, ss, doy and yy=0; edge detector cleared.
//    Reset mid-conversion aborts it with no valid pulse.
//  - Trigger: start & ~start_q in IDLE. Latch wn10/tow_sec that cycle. Edges seen while busy are ignored.
//  - FSM: IDLE -> NORM -> DOW -> HMS -> YEAR -> DONE -> IDLE.
//  - NORM:
//    - wk = wn10 + 1024*WN_ROLLOVER (13b).
//    - If tow_sec >= 604800: subtract 604800, wk += 1.
//    - t = tow - LEAP_SEC.
//    - If tow < LEAP_SEC (borrow): t = tow + 604800 - LEAP_SEC, wk -= 1.
//  - DOW: repeatedly subtract 86400 from t; dow counts 0..6; remainder = sod (17b).
//  - HMS: from sod, subtract 3600 into hh, then 60 into mm; remainder -> ss.
//  - YEAR:
//    - Day count d = wk*7 + dow + 5 (17b, zero-based day of year 1980; epoch = 1980-01-06).
//    - Starting at year 1980, while d >= len(year): d -= len, year++.
//    - len = 366 when year[1:0]==0, else 365 (valid 1980..2099).
//    - doy = d+1; yy = year-2000 (low 7 bits).
//  - DONE: register all outputs together and assert valid for exactly 1 cycle.
//    Outputs hold until the next DONE or reset.
//  - Latency trigger->valid <= 256 cycles for years <= 2099. Must complete well inside one PPS period.
//  - Arithmetic unsigned. Intermediate widths: t 20b, wk 13b, d 17b, year 12b.
//  - start held high across multiple cycles yields exactly one conversion.
// STRUCTURE
//  - Package gps2utc_pkg holds the shared constants:
//    - SEC_PER_DAY=86400, SEC_PER_HOUR=3600, SEC_PER_MIN=60, SEC_PER_WEEK=604800
//    - GPS_EPOCH_YEAR=1980, GPS_EPOCH_DOY0=5
//    - FSM state enum
//  - Sub-module gps_days2yd: iterative day-count -> (year, doy) converter with start/done handshake.
//    Used by the YEAR state.
//  - Parent keeps the normalise, DOW and HMS subtract loops.
// TESTING
//  - rst=0 2 cycles, then rst=1 -> valid=0, all outputs 0. No valid pulse without start.
//  - wn10=314, tow=220007, start high 2 cycles
//    -> one valid pulse; yy=25 doy=105 13:06:29.
//  - Sequence tow=220008, 220009 ... 220013, then +6 (Z-count step) -> ss follows:
//    30, 31 ... 35, then 41.
//  - Borrow: wn10=314, tow=5 -> yy=25 doy=102 23:59:47.
//    Day edge: tow=86417 -> doy=103 23:59:59.
//  - Year edge: wn10=299, tow=259218 -> yy=25 doy=1 00:00:00.
//    tow=259217 -> yy=24 doy=366 23:59:59.
//  - Second start edge mid-conversion is ignored (single valid).
//    rst low mid-conversion -> no valid, outputs 0.

Source files
------------

// File: rtl/gps2utc_pkg.sv
// Shared constants and FSM encoding for the GPS-to-UTC converter.
package gps2utc_pkg;

  localparam int SEC_PER_DAY    = 86400;
  localparam int SEC_PER_HOUR   = 3600;
  localparam int SEC_PER_MIN    = 60;
  localparam int SEC_PER_WEEK   = 604800;
  localparam int GPS_EPOCH_YEAR = 1980;
  localparam int GPS_EPOCH_DOY0 = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_DOW,
    S_HMS,
    S_YEAR,
    S_DONE
  } state_t;

endpackage

// File: rtl/gps_days2yd.sv
// Iterative day count (zero-based from 1980-01-01) to year / day-of-year.
module gps_days2yd
  import gps2utc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [16:0] i_days,
  output logic        o_done,
  output logic [11:0] o_year,
  output logic [8:0]  o_doy
);

  logic        r_busy;
  logic        r_done;
  logic [16:0] r_d;
  logic [11:0] r_year;
  logic [8:0]  w_len;

  // Leap rule by year[1:0] only; exact for 1980..2099.
  assign w_len = (r_year[1:0] == 2'd0) ? 9'd366 : 9'd365;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_d    <= '0;
      r_year <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_d    <= i_days;
        r_year <= 12'(GPS_EPOCH_YEAR);
      end else if (r_busy) begin
        if (r_d >= {8'd0, w_len}) begin
          r_d    <= r_d - {8'd0, w_len};
          r_year <= r_year + 12'd1;
        end else begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_year = r_year;
  assign o_doy  = r_d[8:0] + 9'd1;

endmodule

// File: rtl/gps2utc_ff.sv
// GPS week/TOW to UTC yy/doy/hh:mm:ss, one conversion per PPS edge.
module gps2utc_ff
  import gps2utc_pkg::*;
#(
  parameter int LEAP_SEC    = 18,
  parameter int WN_ROLLOVER = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  wn10,
  input  logic [19:0] tow_sec,
  output logic        valid,
  output logic [5:0]  hh,
  output logic [5:0]  mm,
  output logic [5:0]  ss,
  output logic [8:0]  doy,
  output logic [6:0]  yy
);

  state_t      r_state;
  state_t      w_next;
  logic        r_start_q;
  logic [9:0]  r_wn;
  logic [19:0] r_tow;
  logic [19:0] r_t;
  logic [12:0] r_wk;
  logic [2:0]  r_dow;
  logic [16:0] r_sod;
  logic [4:0]  r_hh;
  logic [5:0]  r_mm;
  logic        r_ystart;
  logic        r_valid;
  logic [5:0]  r_ohh;
  logic [5:0]  r_omm;
  logic [5:0]  r_oss;
  logic [8:0]  r_odoy;
  logic [6:0]  r_oyy;

  logic        w_trig;
  logic [12:0] w_wk0;
  logic        w_ovf;
  logic [19:0] w_tow1;
  logic [12:0] w_wk1;
  logic        w_brw;
  logic [19:0] w_tn;
  logic [12:0] w_wkn;
  logic [16:0] w_days;
  logic        w_day_ge;
  logic        w_hr_ge;
  logic        w_mn_ge;
  logic        w_ydone;
  logic [11:0] w_year;
  logic [8:0]  w_doy;

  assign w_trig = start & ~r_start_q;

  assign w_wk0  = {3'd0, r_wn} + 13'(1024 * WN_ROLLOVER);
  assign w_ovf  = r_tow >= 20'(SEC_PER_WEEK);
  assign w_tow1 = w_ovf ? r_tow - 20'(SEC_PER_WEEK) : r_tow;
  assign w_wk1  = w_ovf ? w_wk0 + 13'd1 : w_wk0;
  assign w_brw  = w_tow1 < 20'(LEAP_SEC);
  assign w_tn   = w_brw ? w_tow1 + 20'(SEC_PER_WEEK - LEAP_SEC)
                        : w_tow1 - 20'(LEAP_SEC);
  assign w_wkn  = w_brw ? w_wk1 - 13'd1 : w_wk1;

  // wk*7 as (wk<<3)-wk
  assign w_days = {1'b0, r_wk, 3'd0} - 17'(r_wk)
                + 17'(r_dow) + 17'(GPS_EPOCH_DOY0);

  assign w_day_ge = r_t >= 20'(SEC_PER_DAY);
  assign w_hr_ge  = r_sod >= 17'(SEC_PER_HOUR);
  assign w_mn_ge  = r_sod >= 17'(SEC_PER_MIN);

  gps_days2yd u_days2yd (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_ystart),
    .i_days  (w_days),
    .o_done  (w_ydone),
    .o_year  (w_year),
    .o_doy   (w_doy)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_trig) w_next = S_NORM;
      S_NORM: w_next = S_DOW;
      S_DOW:  if (!w_day_ge) w_next = S_HMS;
      S_HMS:  if (!w_hr_ge && !w_mn_ge) w_next = S_YEAR;
      S_YEAR: if (w_ydone) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_start_q <= 1'b0;
      r_wn      <= '0;
      r_tow     <= '0;
      r_t       <= '0;
      r_wk      <= '0;
      r_dow     <= '0;
      r_sod     <= '0;
      r_hh      <= '0;
      r_mm      <= '0;
      r_ystart  <= 1'b0;
      r_valid   <= 1'b0;
      r_ohh     <= '0;
      r_omm     <= '0;
      r_oss     <= '0;
      r_odoy    <= '0;
      r_oyy     <= '0;
    end else begin
      r_start_q <= start;
      r_valid   <= 1'b0;
      r_ystart  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_wn  <= wn10;
            r_tow <= tow_sec;
          end
        end
        S_NORM: begin
          r_t   <= w_tn;
          r_wk  <= w_wkn;
          r_dow <= '0;
          r_hh  <= '0;
          r_mm  <= '0;
        end
        S_DOW: begin
          if (w_day_ge) begin
            r_t   <= r_t - 20'(SEC_PER_DAY);
            r_dow <= r_dow + 3'd1;
          end else begin
            r_sod <= r_t[16:0];
          end
        end
        S_HMS: begin
          if (w_hr_ge) begin
            r_sod <= r_sod - 17'(SEC_PER_HOUR);
            r_hh  <= r_hh + 5'd1;
          end else if (w_mn_ge) begin
            r_sod <= r_sod - 17'(SEC_PER_MIN);
            r_mm  <= r_mm + 6'd1;
          end else begin
            r_ystart <= 1'b1;
          end
        end
        S_YEAR: ;
        S_DONE: begin
          r_ohh   <= {1'b0, r_hh};
          r_omm   <= r_mm;
          r_oss   <= r_sod[5:0];
          r_odoy  <= w_doy;
          r_oyy   <= 7'(w_year - 12'd2000);
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign valid = r_valid;
  assign hh    = r_ohh;
  assign mm    = r_omm;
  assign ss    = r_oss;
  assign doy   = r_odoy;
  assign yy    = r_oyy;

endmodule

// File: tb/tb_gps2utc_ff.sv
// Scoreboard bench for gps2utc_ff: directed calendar edges plus random GPS times.
module tb_gps2utc_ff;

  localparam int LEAP = 18;
  localparam int ROLL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  wn10 = '0;
  logic [19:0] tow_sec = '0;
  logic        valid;
  logic [5:0]  hh;
  logic [5:0]  mm;
  logic [5:0]  ss;
  logic [8:0]  doy;
  logic [6:0]  yy;

  int total = 0;
  int bad = 0;
  logic [33:0] q[$];
  logic [33:0] m_exp;

  gps2utc_ff #(.LEAP_SEC(LEAP), .WN_ROLLOVER(ROLL)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .wn10    (wn10),
    .tow_sec (tow_sec),
    .valid   (valid),
    .hh      (hh),
    .mm      (mm),
    .ss      (ss),
    .doy     (doy),
    .yy      (yy)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] pack(input int y, input int d,
                                       input int h, input int m,
                                       input int s);
    return {7'(y), 9'(d), 6'(h), 6'(m), 6'(s)};
  endfunction

  // Absolute seconds since the GPS epoch, then calendar arithmetic.
  function automatic logic [33:0] model(input int wn, input int tow);
    longint tot;
    longint days;
    longint sod;
    longint d;
    int yr;
    int len;
    tot  = longint'(wn + 1024 * ROLL) * 604800 + tow - LEAP;
    days = tot / 86400;
    sod  = tot % 86400;
    d    = days + 5;
    yr   = 1980;
    while (1) begin
      len = (yr % 4 == 0) ? 366 : 365;
      if (d < len) break;
      d  = d - len;
      yr = yr + 1;
    end
    return pack(yr - 2000, int'(d) + 1, int'(sod / 3600),
                int'((sod % 3600) / 60), int'(sod % 60));
  endfunction

  task automatic chk(input string nm, input logic [33:0] got,
                     input logic [33:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got yy=%0d doy=%0d %0d:%0d:%0d",
                 yy, doy, hh, mm, ss);
      end else begin
        m_exp = q.pop_front();
        if ({yy, doy, hh, mm, ss} !== m_exp) begin
          bad++;
          $display("FAIL result got yy=%0d doy=%0d %0d:%0d:%0d exp yy=%0d doy=%0d %0d:%0d:%0d",
                   yy, doy, hh, mm, ss, m_exp[33:27], m_exp[26:18],
                   m_exp[17:12], m_exp[11:6], m_exp[5:0]);
        end
      end
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    while (!valid && n < 260) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      total++;
      bad++;
      $display("FAIL timeout got=no_valid exp=valid_within_256");
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic conv(input logic [9:0] wn, input logic [19:0] tow,
                      input int hold, input logic [33:0] exp);
    @(negedge clk);
    wn10    = wn;
    tow_sec = tow;
    q.push_back(exp);
    start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    wait_valid();
  endtask

  initial begin
    int wn;
    int tow;
    int sel;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_out", {yy, doy, hh, mm, ss}, 34'd0);
    chk("reset_valid", {33'd0, valid}, 34'd0);
    repeat (20) @(negedge clk);

    conv(10'd314, 20'd220007, 2, pack(25, 105, 13, 6, 29));
    for (int i = 0; i < 6; i++)
      conv(10'd314, 20'(220008 + i), 1, pack(25, 105, 13, 6, 30 + i));
    conv(10'd314, 20'd220019, 1, pack(25, 105, 13, 6, 41));
    conv(10'd314, 20'd5, 1, pack(25, 102, 23, 59, 47));
    conv(10'd314, 20'd86417, 3, pack(25, 103, 23, 59, 59));
    conv(10'd299, 20'd259218, 1, pack(25, 1, 0, 0, 0));
    conv(10'd299, 20'd259217, 1, pack(24, 366, 23, 59, 59));
    conv(10'd314, 20'd824807, 1, model(314, 824807));

    // second edge while busy must be ignored
    @(negedge clk);
    wn10    = 10'd314;
    tow_sec = 20'd220007;
    q.push_back(pack(25, 105, 13, 6, 29));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    wn10    = 10'd100;
    tow_sec = 20'd1000;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_valid();
    repeat (300) @(negedge clk);

    // reset in the middle of a conversion
    @(negedge clk);
    wn10    = 10'd500;
    tow_sec = 20'd300000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort_out", {yy, doy, hh, mm, ss}, 34'd0);
    chk("abort_valid", {33'd0, valid}, 34'd0);

    for (int i = 0; i < 25; i++) begin
      wn  = int'($urandom_range(0, 1023));
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      tow = int'($urandom_range(0, 17));
      else if (sel == 1) tow = int'($urandom_range(604800, 1048575));
      else               tow = int'($urandom_range(0, 604799));
      conv(10'(wn), 20'(tow), int'($urandom_range(1, 3)), model(wn, tow));
    end

    repeat (10) @(negedge clk);
    chk("queue_empty", 34'(q.size()), 34'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
